// File: rtl/seq_controller.sv
// Multi-cycle sequencer for the sequential Y86-64 core: owns the PC,
// steps the stage enables, handshakes data memory and tracks status.
module seq_controller #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             cnd,
    input  logic [63:0]      valP,
    input  logic [63:0]      valC,
    input  logic [63:0]      valM,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             mem_req,
    output logic [4:0]       stage_en,
    output logic [63:0]      pc,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
        S_WRITEBACK, S_PCUPD, S_HALT, S_ERR
    } state_t;

    localparam logic [2:0] ST_AOK = 3'd1;
    localparam logic [2:0] ST_HLT = 3'd2;
    localparam logic [2:0] ST_ADR = 3'd3;
    localparam logic [2:0] ST_INS = 3'd4;
    localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [2:0]       stat_q, stat_d;
    logic [15:0]      wait_q, wait_d;
    logic [4:0]       en_q, en_d;
    logic             req_q, req_d;
    logic             halt_q, halt_d;
    logic             mem_cls;

    assign mem_cls = (icode == 4'd4) || (icode == 4'd5) ||
                     (icode == 4'd8) || (icode == 4'd9) ||
                     (icode == 4'd10) || (icode == 4'd11);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        stat_d  = stat_q;
        wait_d  = '0;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    state_d = S_ERR;
                    stat_d  = ST_ADR;
                end else if (!instr_valid) begin
                    state_d = S_ERR;
                    stat_d  = ST_INS;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (icode > 4'd11) begin
                    state_d = S_ERR;
                    stat_d  = ST_INS;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                // mem_ready is checked before the timeout so it wins a tie
                if (!mem_cls) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ready) begin
                    state_d = dmem_error ? S_ERR : S_WRITEBACK;
                    if (dmem_error) stat_d = ST_ADR;
                end else if (wait_q == TO_LAST) begin
                    state_d = S_ERR;
                    stat_d  = ST_ADR;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                ret_d   = ret_q + 1'b1;
                state_d = S_FETCH;
                unique case (icode)
                    4'd0: begin
                        state_d = S_HALT;
                        stat_d  = ST_HLT;
                    end
                    4'd7:    pc_d = cnd ? valC : valP;
                    4'd8:    pc_d = valC;
                    4'd9:    pc_d = valM;
                    default: pc_d = valP;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_comb begin
        en_d   = '0;
        req_d  = 1'b0;
        halt_d = 1'b0;
        unique case (state_d)
            S_FETCH:     en_d = 5'b00001;
            S_DECODE:    en_d = 5'b00010;
            S_EXECUTE:   en_d = 5'b00100;
            S_MEMORY: begin
                en_d  = 5'b01000;
                req_d = mem_cls;
            end
            S_WRITEBACK: en_d = 5'b10000;
            S_HALT, S_ERR: halt_d = 1'b1;
            default:     en_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ret_q   <= '0;
            stat_q  <= ST_AOK;
            wait_q  <= '0;
            en_q    <= '0;
            req_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
            stat_q  <= stat_d;
            wait_q  <= wait_d;
            en_q    <= en_d;
            req_q   <= req_d;
            halt_q  <= halt_d;
        end
    end

    assign mem_req  = req_q;
    assign stage_en = en_q;
    assign pc       = pc_q;
    assign stat     = stat_q;
    assign halted   = halt_q;
    assign retired  = ret_q;

endmodule
